// File: rtl/tof_udp_packet_arbiter.sv
// ---------------------------------------------------------------------------
// tof_udp_packet_arbiter
//
// Packet-level round-robin arbiter that merges NUM_PORTS HELIX-framed 16-bit
// AXI4-Stream sources into the single stream feeding the TOF UDP flow buffer.
// HELIX framing: tuser=1 marks the first beat of a packet, tlast the final one.
//
// A grant is held from the first beat to tlast, so packets never interleave.
// The block also enforces the flow buffer's framing limits:
//   * 1-word packets (runts) are dropped and counted,
//   * packets longer than MAX_WORDS are cut at MAX_WORDS (last forwarded beat
//     gets tlast forced) and the remainder is swallowed; counted once,
//   * beats arriving at the start of a grant without tuser are dropped one
//     at a time and counted.
//
// Ports
//   aclk, areset        clock, synchronous active-high reset
//   port_enable         per-port arbitration enable (sampled only when idle)
//   s_axis_t*           NUM_PORTS slave streams, port i data in [16i+15:16i]
//   m_axis_t*           merged stream, driven from a 1-entry output register
//   grant_id            port currently or most recently granted
//   busy                arbiter is inside a grant (not idle)
//   runt_count          saturating count of dropped runt packets
//   trunc_count         saturating count of truncated packets
//   framing_count       saturating count of dropped stray beats
// ---------------------------------------------------------------------------
module tof_udp_packet_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int MAX_WORDS = 1024,
  parameter int CNT_W     = 16
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [NUM_PORTS-1:0]    port_enable,
  input  logic [16*NUM_PORTS-1:0] s_axis_tdata,
  input  logic [NUM_PORTS-1:0]    s_axis_tvalid,
  output logic [NUM_PORTS-1:0]    s_axis_tready,
  input  logic [NUM_PORTS-1:0]    s_axis_tlast,
  input  logic [NUM_PORTS-1:0]    s_axis_tuser,
  output logic [15:0]             m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tuser,
  output logic [2:0]              grant_id,
  output logic                    busy,
  output logic [CNT_W-1:0]        runt_count,
  output logic [CNT_W-1:0]        trunc_count,
  output logic [CNT_W-1:0]        framing_count
);

  localparam int              WC_W      = $clog2(MAX_WORDS + 1);
  localparam logic [2:0]      LAST_PORT = 3'(NUM_PORTS - 1);
  localparam logic [WC_W-1:0] WC_MAX    = WC_W'(MAX_WORDS);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FIRST   = 2'd1,
    S_PASS    = 2'd2,
    S_DISCARD = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        rr_q, rr_d;
  logic [2:0]        grant_q, grant_d;
  logic [WC_W-1:0]   word_cnt_q, word_cnt_d;

  logic [15:0]       m_data_q, m_data_d;
  logic              m_valid_q, m_valid_d;
  logic              m_last_q, m_last_d;
  logic              m_user_q, m_user_d;

  logic [CNT_W-1:0]  runt_q, runt_d;
  logic [CNT_W-1:0]  trunc_q, trunc_d;
  logic [CNT_W-1:0]  framing_q, framing_d;

  logic [15:0]          port_data [NUM_PORTS];
  logic [NUM_PORTS-1:0] port_sel;
  logic [NUM_PORTS-1:0] cand;

  logic        g_valid, g_last, g_user, g_ready;
  logic [15:0] g_data;
  logic        accept, slot_free, cand_found;
  logic [2:0]  rr_pick;

  function automatic logic [2:0] wrap_inc(input logic [2:0] p);
    return (p == LAST_PORT) ? 3'd0 : p + 3'd1;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // Per-port slicing, grant decode and ready fan-out. Only the granted port
  // ever sees tready; in idle g_ready is 0 so no port does.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      assign port_data[gi]     = s_axis_tdata[16*gi +: 16];
      assign port_sel[gi]      = (grant_q == 3'(gi));
      assign s_axis_tready[gi] = port_sel[gi] & g_ready;
    end
  endgenerate

  // Mux of the granted port's stream signals.
  always_comb begin
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_user  = 1'b0;
    g_data  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (port_sel[i]) begin
        g_valid = s_axis_tvalid[i];
        g_last  = s_axis_tlast[i];
        g_user  = s_axis_tuser[i];
        g_data  = port_data[i];
      end
    end
  end

  assign cand = s_axis_tvalid & port_enable;

  // Round-robin pick: scan rr_q, rr_q+1, ... (mod NUM_PORTS). The outer loop
  // runs from the farthest offset down so the nearest candidate is written
  // last and wins.
  always_comb begin
    rr_pick    = rr_q;
    cand_found = 1'b0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (cand[i] && (((int'(rr_q) + k) % NUM_PORTS) == i)) begin
          rr_pick    = 3'(i);
          cand_found = 1'b1;
        end
      end
    end
  end

  assign slot_free = !m_valid_q || m_axis_tready;

  // While forwarding, the input only moves when the output slot can take the
  // beat; while discarding the tail of an over-long packet it always moves.
  always_comb begin
    case (state_q)
      S_FIRST, S_PASS: g_ready = slot_free;
      S_DISCARD:       g_ready = 1'b1;
      default:         g_ready = 1'b0;
    endcase
  end

  assign accept = g_valid & g_ready;

  // Next-state, output register load and counter updates.
  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    grant_d    = grant_q;
    word_cnt_d = word_cnt_q;
    // A held beat leaves the register once the sink takes it.
    m_valid_d  = m_valid_q & ~m_axis_tready;
    m_data_d   = m_data_q;
    m_last_d   = m_last_q;
    m_user_d   = m_user_q;
    runt_d     = runt_q;
    trunc_d    = trunc_q;
    framing_d  = framing_q;

    case (state_q)
      S_IDLE: begin
        // Arbitration cycle only; no beat is taken here.
        if (cand_found) begin
          grant_d = rr_pick;
          state_d = S_FIRST;
        end
      end

      S_FIRST: begin
        if (accept) begin
          if (!g_user) begin
            // Stray beat: drop it and re-arbitrate without moving rr, so the
            // same port gets a fair new chance at its next beat.
            framing_d = sat_inc(framing_q);
            state_d   = S_IDLE;
          end else if (g_last) begin
            runt_d  = sat_inc(runt_q);
            rr_d    = wrap_inc(grant_q);
            state_d = S_IDLE;
          end else begin
            m_valid_d  = 1'b1;
            m_data_d   = g_data;
            m_last_d   = 1'b0;
            m_user_d   = 1'b1;
            word_cnt_d = WC_W'(1);
            state_d    = S_PASS;
          end
        end
      end

      S_PASS: begin
        if (accept) begin
          word_cnt_d = word_cnt_q + WC_W'(1);
          m_valid_d  = 1'b1;
          m_data_d   = g_data;
          m_user_d   = 1'b0;
          if (g_last) begin
            m_last_d = 1'b1;
            rr_d     = wrap_inc(grant_q);
            state_d  = S_IDLE;
          end else if ((word_cnt_q + WC_W'(1)) == WC_MAX) begin
            // Packet hit the size limit: close it here and swallow the rest.
            m_last_d = 1'b1;
            trunc_d  = sat_inc(trunc_q);
            state_d  = S_DISCARD;
          end else begin
            m_last_d = 1'b0;
          end
        end
      end

      S_DISCARD: begin
        if (accept && g_last) begin
          rr_d    = wrap_inc(grant_q);
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q    <= S_IDLE;
      rr_q       <= '0;
      grant_q    <= '0;
      word_cnt_q <= '0;
      m_data_q   <= '0;
      m_valid_q  <= 1'b0;
      m_last_q   <= 1'b0;
      m_user_q   <= 1'b0;
      runt_q     <= '0;
      trunc_q    <= '0;
      framing_q  <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      grant_q    <= grant_d;
      word_cnt_q <= word_cnt_d;
      m_data_q   <= m_data_d;
      m_valid_q  <= m_valid_d;
      m_last_q   <= m_last_d;
      m_user_q   <= m_user_d;
      runt_q     <= runt_d;
      trunc_q    <= trunc_d;
      framing_q  <= framing_d;
    end
  end

  assign m_axis_tdata  = m_data_q;
  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tlast  = m_last_q;
  assign m_axis_tuser  = m_user_q;
  assign grant_id      = grant_q;
  assign busy          = (state_q != S_IDLE);
  assign runt_count    = runt_q;
  assign trunc_count   = trunc_q;
  assign framing_count = framing_q;

endmodule

// File: tb/tb_tof_udp_packet_arbiter.sv
// ---------------------------------------------------------------------------
// tb_tof_udp_packet_arbiter
//
// Self-checking bench. Each port has a beat memory filled with packets; a
// driver presents them with optional random valid gaps. A packet-level
// reference model (owner port, beat index within the grant, expected output
// queue, expected counters) is advanced from the beats that actually hand
// over on the wire and is compared against the DUT every cycle. Directed
// scenarios additionally pin literal values derived from the stimulus.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_tof_udp_packet_arbiter;
  localparam int NP = 4;
  localparam int MW = 1024;
  localparam int CW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              areset;
  logic [NP-1:0]     port_enable;
  logic [16*NP-1:0]  s_tdata;
  logic [NP-1:0]     s_tvalid, s_tready, s_tlast, s_tuser;
  logic [15:0]       m_tdata;
  logic              m_tvalid, m_tready, m_tlast, m_tuser;
  logic [2:0]        grant_id;
  logic              busy;
  logic [CW-1:0]     runt_count, trunc_count, framing_count;

  tof_udp_packet_arbiter #(.NUM_PORTS(NP), .MAX_WORDS(MW), .CNT_W(CW)) dut (
    .aclk          (clk),
    .areset        (areset),
    .port_enable   (port_enable),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tlast  (s_tlast),
    .s_axis_tuser  (s_tuser),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tlast  (m_tlast),
    .m_axis_tuser  (m_tuser),
    .grant_id      (grant_id),
    .busy          (busy),
    .runt_count    (runt_count),
    .trunc_count   (trunc_count),
    .framing_count (framing_count)
  );

  int n_chk, n_pass, cyc;

  // Stimulus: beat = {user, last, data}
  logic [17:0]   pmem [NP][4096];
  int            wr_ptr [NP];
  int            rd_ptr [NP];
  logic [NP-1:0] vld, acc;
  int            gap_pct, rdy_mode, en_mode;

  // Reference model
  int          owner, beat_idx, rr;
  bit          dropping;
  logic [2:0]  exp_grant;
  int          exp_runt, exp_trunc, exp_frame;
  logic [17:0] expq [$];
  bit          hold_valid, rst_prev;
  logic [17:0] hold_val;

  // Output logs for literal checks
  int          out_n, gl_n;
  int          out_cyc [2048];
  logic [1:0]  out_flags [2048];
  int          gl [64];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic void model_reset();
    owner = -1; beat_idx = 0; dropping = 1'b0; rr = 0; exp_grant = 3'd0;
    exp_runt = 0; exp_trunc = 0; exp_frame = 0;
    expq.delete();
    hold_valid = 1'b0;
  endfunction

  function automatic void clear_logs();
    out_n = 0; gl_n = 0;
    for (int i = 0; i < 64; i++) gl[i] = -1;
  endfunction

  function automatic void add_pkt(input int p, input int len, input bit bad_first);
    for (int i = 0; i < len; i++) begin
      pmem[p][wr_ptr[p]] = {(i == 0) && !bad_first, (i == len - 1), 16'($urandom)};
      wr_ptr[p]++;
    end
  endfunction

  // Compare DUT against the model (state after the previous edge), then
  // advance the model with what hands over at the coming edge.
  task automatic monitor();
    logic [17:0]   b, got;
    logic [NP-1:0] exp_rdy;
    int            pick, idx;
    got = {m_tuser, m_tlast, m_tdata};
    chk("busy", 64'(busy), 64'(owner >= 0));
    chk("grant_id", 64'(grant_id), 64'(exp_grant));
    chk("runt_count", 64'(runt_count), 64'(exp_runt));
    chk("trunc_count", 64'(trunc_count), 64'(exp_trunc));
    chk("framing_count", 64'(framing_count), 64'(exp_frame));
    chk("m_tvalid", 64'(m_tvalid), 64'(expq.size() != 0));
    if (rst_prev) chk("reset_m_out", 64'(got), 64'(0));
    if (hold_valid) chk("m_hold_stable", 64'(got), 64'(hold_val));
    for (int p = 0; p < NP; p++) begin
      exp_rdy[p] = 1'b0;
      if (owner == p) exp_rdy[p] = dropping ? 1'b1 : ((expq.size() == 0) || m_tready);
    end
    chk("s_tready", 64'(s_tready), 64'(exp_rdy));

    if (m_tvalid && m_tready) begin
      if (expq.size() == 0) chk("m_extra_beat", 64'(m_tvalid), 64'(0));
      else chk("m_beat", 64'(got), 64'(expq.pop_front()));
      if (out_n < 2048) begin
        out_cyc[out_n]   = cyc;
        out_flags[out_n] = {m_tlast, m_tuser};
      end
      if (m_tuser && gl_n < 64) begin
        gl[gl_n] = int'(grant_id);
        gl_n++;
      end
      out_n++;
    end
    hold_valid = m_tvalid && !m_tready;
    hold_val   = got;

    acc = vld & s_tready;
    if (areset) begin
      model_reset();
      rst_prev = 1'b1;
    end else begin
      rst_prev = 1'b0;
      if (owner < 0) begin
        pick = -1;
        for (int k = NP - 1; k >= 0; k--) begin
          idx = (rr + k) % NP;
          if (vld[idx] && port_enable[idx]) pick = idx;
        end
        if (pick >= 0) begin
          owner = pick; exp_grant = 3'(pick); beat_idx = 0; dropping = 1'b0;
        end
      end else if (acc[owner]) begin
        b = pmem[owner][rd_ptr[owner]];
        if (beat_idx == 0) begin
          if (!b[17]) begin
            exp_frame++; owner = -1;
          end else if (b[16]) begin
            exp_runt++; rr = (owner + 1) % NP; owner = -1;
          end else begin
            expq.push_back({2'b10, b[15:0]}); beat_idx = 1;
          end
        end else if (dropping) begin
          if (b[16]) begin rr = (owner + 1) % NP; owner = -1; end
        end else begin
          beat_idx++;
          if (b[16]) begin
            expq.push_back({2'b01, b[15:0]}); rr = (owner + 1) % NP; owner = -1;
          end else if (beat_idx == MW) begin
            expq.push_back({2'b01, b[15:0]}); exp_trunc++; dropping = 1'b1;
          end else begin
            expq.push_back({2'b00, b[15:0]});
          end
        end
      end
    end
  endtask

  task automatic drive();
    logic [17:0] b;
    for (int p = 0; p < NP; p++) begin
      if (acc[p]) begin rd_ptr[p]++; vld[p] = 1'b0; end
      if (!vld[p] && rd_ptr[p] < wr_ptr[p] && $urandom_range(99) >= gap_pct) vld[p] = 1'b1;
      b = (rd_ptr[p] < wr_ptr[p]) ? pmem[p][rd_ptr[p]] : 18'd0;
      s_tdata[16*p +: 16] = b[15:0];
      s_tlast[p] = b[16];
      s_tuser[p] = b[17];
      port_enable[p] = (en_mode == 0) ? 1'b1 : ($urandom_range(99) < 85);
    end
    s_tvalid = vld;
    case (rdy_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = (cyc % 4 == 0) || (cyc % 4 == 3);
      default: m_tready = ($urandom_range(99) < 70);
    endcase
    acc = '0;
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
    drive();
  endtask

  function automatic bit drained();
    bit d;
    d = (expq.size() == 0) && (owner < 0) && (vld == '0);
    for (int p = 0; p < NP; p++) if (rd_ptr[p] != wr_ptr[p]) d = 1'b0;
    return d;
  endfunction

  task automatic run_until_done(input int budget);
    int n;
    n = 0;
    while (!drained() && n < budget) begin step(); n++; end
    if (!drained()) begin
      n_chk++;
      $display("FAIL drain_timeout: still busy after %0d cycles (cycle %0d)", n, cyc);
    end
    repeat (3) step();
  endtask

  task automatic do_reset();
    areset = 1'b1;
    step();
    step();
    areset = 1'b0;
    for (int p = 0; p < NP; p++) begin wr_ptr[p] = 0; rd_ptr[p] = 0; end
    vld = '0;
    clear_logs();
  endtask

  initial begin
    int n, strays, exp_out, exp_r, exp_f, p, r, len;
    bit bad;
    n_chk = 0; n_pass = 0; cyc = 0;
    areset = 1'b1; vld = '0; acc = '0;
    s_tvalid = '0; s_tdata = '0; s_tlast = '0; s_tuser = '0;
    m_tready = 1'b0; port_enable = '1;
    gap_pct = 0; rdy_mode = 0; en_mode = 0;
    for (int i = 0; i < NP; i++) begin wr_ptr[i] = 0; rd_ptr[i] = 0; end
    model_reset(); rst_prev = 1'b0; clear_logs();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Reset state
    chk("rst_m_tvalid", 64'(m_tvalid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_grant", 64'(grant_id), 64'(0));
    chk("rst_tready", 64'(s_tready), 64'(0));
    chk("rst_counts", 64'({runt_count, trunc_count, framing_count}), 64'(0));

    // 1: ports 0 and 2 together, then 0 and 3 to show rr moved past 2
    add_pkt(0, 4, 1'b0); add_pkt(2, 4, 1'b0);
    run_until_done(200);
    chk("t1_beats", 64'(out_n), 64'(8));
    chk("t1_first_grant", 64'(gl[0]), 64'(0));
    chk("t1_second_grant", 64'(gl[1]), 64'(2));
    chk("t1_flags_b0", 64'(out_flags[0]), 64'(2'b01));
    chk("t1_flags_b3", 64'(out_flags[3]), 64'(2'b10));
    chk("t1_flags_b4", 64'(out_flags[4]), 64'(2'b01));
    chk("t1_flags_b7", 64'(out_flags[7]), 64'(2'b10));
    chk("t1_back_to_back", 64'(out_cyc[1] - out_cyc[0]), 64'(1));
    chk("t1_bubble", 64'(out_cyc[4] - out_cyc[3]), 64'(2));
    clear_logs();
    add_pkt(0, 2, 1'b0); add_pkt(3, 2, 1'b0);
    run_until_done(100);
    chk("t1_rr3_first", 64'(gl[0]), 64'(3));
    chk("t1_rr3_second", 64'(gl[1]), 64'(0));

    // 2: all ports busy, 12 packets of 5 words
    do_reset();
    for (int k = 0; k < 3; k++) for (int q = 0; q < NP; q++) add_pkt(q, 5, 1'b0);
    run_until_done(400);
    chk("t2_packets", 64'(gl_n), 64'(12));
    chk("t2_beats", 64'(out_n), 64'(60));
    for (int i = 0; i < 12; i++) chk("t2_grant_order", 64'(gl[i]), 64'(i % NP));

    // 3: runt then a normal packet on port 1
    do_reset();
    add_pkt(1, 1, 1'b0); add_pkt(1, 4, 1'b0);
    run_until_done(100);
    chk("t3_runt_count", 64'(runt_count), 64'(1));
    chk("t3_beats", 64'(out_n), 64'(4));
    chk("t3_grant", 64'(gl[0]), 64'(1));

    // 4: over-long packet is cut at MW words
    do_reset();
    add_pkt(0, 1030, 1'b0);
    run_until_done(3000);
    chk("t4_beats", 64'(out_n), 64'(MW));
    chk("t4_first_flags", 64'(out_flags[0]), 64'(2'b01));
    chk("t4_mid_flags", 64'(out_flags[MW-2]), 64'(2'b00));
    chk("t4_last_flags", 64'(out_flags[MW-1]), 64'(2'b10));
    chk("t4_trunc_count", 64'(trunc_count), 64'(1));
    chk("t4_idle", 64'(busy), 64'(0));

    // 5: throttled sink, reset mid-packet, leftovers become stray beats
    do_reset();
    rdy_mode = 1;
    add_pkt(0, 6, 1'b0);
    n = 0;
    while (rd_ptr[0] < 3 && n < 100) begin step(); n++; end
    if (rd_ptr[0] < 3) begin
      n_chk++;
      $display("FAIL t5_reach_word3: only %0d words taken (cycle %0d)", rd_ptr[0], cyc);
    end
    areset = 1'b1;
    step();
    areset = 1'b0;
    chk("t5_after_reset_valid", 64'(m_tvalid), 64'(0));
    chk("t5_after_reset_busy", 64'(busy), 64'(0));
    strays = wr_ptr[0] - rd_ptr[0];
    run_until_done(200);
    chk("t5_framing_count", 64'(framing_count), 64'(strays));
    chk("t5_runt_count", 64'(runt_count), 64'(0));
    rdy_mode = 0;

    // 6: random mix with gaps, enables and back-pressure
    do_reset();
    gap_pct = 40; rdy_mode = 2; en_mode = 1;
    exp_out = 0; exp_r = 0; exp_f = 0;
    for (int i = 0; i < 60; i++) begin
      p = $urandom_range(NP - 1);
      r = $urandom_range(99);
      len = (r < 10) ? 1 : $urandom_range(12, 2);
      bad = (r >= 10 && r < 20);
      add_pkt(p, len, bad);
      if (bad) exp_f += len;
      else if (len == 1) exp_r++;
      else exp_out += len;
    end
    run_until_done(20000);
    chk("t6_beats", 64'(out_n), 64'(exp_out));
    chk("t6_runt_count", 64'(runt_count), 64'(exp_r));
    chk("t6_framing_count", 64'(framing_count), 64'(exp_f));
    chk("t6_trunc_count", 64'(trunc_count), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
